// File: rtl/sine_sample_requester.sv
// Requests samples from the sine reader one at a time and prefetches them into a small FIFO.
// Optional WAIT watchdog enabled by defining SINE_REQ_TIMEOUT_EN.
module sine_sample_requester #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  output logic                          generate_next,
  input  logic                          sample_ready,
  input  logic signed [15:0]            sample,
  input  logic                          pop,
  output logic signed [15:0]            out_sample,
  output logic                          out_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          underrun,
  output logic                          timeout
);

  localparam int DATA_W = 16;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sine_sample_requester: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_WAIT} state_t;

  state_t                    state_q, state_d;
  logic                      gen_q, gen_d;
  logic                      push;
  logic                      pop_eff;
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0]         fill_q, fill_d;
  logic signed [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic signed [DATA_W-1:0]  hold_q;
  logic                      underrun_q;

`ifdef SINE_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]          wait_cnt_q;
  logic                      timeout_q;
  logic                      timeout_hit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef SINE_REQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      S_IDLE:    if (enable && (fill_q < FILL_W'(FIFO_DEPTH))) state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT: begin
        // A response landing on the expiry cycle takes priority over the abort.
        if (sample_ready) begin
          state_d = S_IDLE;
        end
`ifdef SINE_REQ_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push  = (state_q == S_WAIT) && sample_ready;
    gen_d = (state_d == S_REQUEST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gen_q <= 1'b0;
    else       gen_q <= gen_d;
  end

  assign generate_next = gen_q;

  // ---- prefetch FIFO ----
  assign out_valid  = (fill_q != '0);
  assign pop_eff    = pop && out_valid;
  assign out_sample = out_valid ? mem_q[rd_ptr_q] : hold_q;
  assign fill       = fill_q;
  assign underrun   = underrun_q;

  always_comb begin
    fill_d = fill_q;
    case ({push, pop_eff})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      hold_q     <= '0;
      underrun_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= sample;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_eff) begin
        hold_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (pop && !out_valid) underrun_q <= 1'b1;
      fill_q <= fill_d;
    end
  end

`ifdef SINE_REQ_TIMEOUT_EN
  // ---- WAIT watchdog ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == S_REQUEST)   wait_cnt_q <= '0;
      else if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
